frame_stream_source: RTL and testbench



---
 rtl/video_stream_pkg.sv | 24 ++
 rtl/stream_fifo.sv | 72 +++++++
 rtl/frame_stream_source.sv | 131 +++++++++++++
 tb/tb_frame_stream_source.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_stream_pkg.sv
// Shared types for the 12-bit RGB444 Avalon-ST video stream used by the
// frame source and the filter chain.
package video_stream_pkg;

    localparam int PIX_W      = 12;
    localparam int IMG_WIDTH  = 320;
    localparam int IMG_HEIGHT = 240;
    localparam int FRAME_LEN  = IMG_WIDTH * IMG_HEIGHT;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        pixel_t data;
        logic   sop;
        logic   eop;
    } stream_beat_t;

    typedef enum logic [1:0] {
        FSS_IDLE,
        FSS_STREAM,
        FSS_DRAIN
    } fss_state_e;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO of stream beats. The head entry is
// visible on dout whenever the FIFO is not empty.
module stream_fifo
    import video_stream_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  stream_beat_t               din,
    input  logic                       pop,
    output stream_beat_t               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    stream_beat_t    mem_q [DEPTH];
    stream_beat_t    mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/frame_stream_source.sv
// Reads one frame from the frame buffer in raster order on a start pulse and
// emits it as a single Avalon-ST packet (sop on pixel 0, eop on the last pixel).
module frame_stream_source #(
    parameter int IMG_WIDTH  = video_stream_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = video_stream_pkg::IMG_HEIGHT,
    parameter int PIX_W      = video_stream_pkg::PIX_W,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    input  logic              ready_in,
    output logic              valid_out,
    output logic              startofpacket_out,
    output logic              endofpacket_out,
    output logic [PIX_W-1:0]  data_out
);

    import video_stream_pkg::*;

    localparam int                LEN       = IMG_WIDTH * IMG_HEIGHT;
    localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN - 1);

    fss_state_e        state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic              sop_pend_q, sop_pend_d;
    logic              eop_pend_q, eop_pend_d;

    stream_beat_t      push_beat, head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty, pop;
    logic [CW:0]       occupancy;

    // Entries already stored plus the read whose data arrives next cycle;
    // bounding this by the depth is what makes overflow impossible.
    assign occupancy = {1'b0, fifo_count} + (CW + 1)'(inflight_q);
    assign rd_en     = (state_q == FSS_STREAM) && !fifo_full
                       && (occupancy < (CW + 1)'(FIFO_DEPTH));
    assign pop       = !fifo_empty && ready_in;
    assign push_beat = '{data: rd_data, sop: sop_pend_q, eop: eop_pend_q};

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        addr_d     = addr_q;
        inflight_d = rd_en;
        sop_pend_d = sop_pend_q;
        eop_pend_d = eop_pend_q;
        if (rd_en) begin
            sop_pend_d = (addr_q == '0);
            eop_pend_d = (addr_q == LAST_ADDR);
            addr_d     = addr_q + 1'b1;
        end
        case (state_q)
            FSS_IDLE: begin
                if (start) begin
                    state_d = FSS_STREAM;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                end
            end
            FSS_STREAM: begin
                if (rd_en && (addr_q == LAST_ADDR)) begin
                    state_d = FSS_DRAIN;
                end
            end
            FSS_DRAIN: begin
                if (pop && head.eop) begin
                    state_d = FSS_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = FSS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FSS_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            sop_pend_q <= 1'b0;
            eop_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            sop_pend_q <= sop_pend_d;
            eop_pend_q <= eop_pend_d;
        end
    end

    stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   (push_beat),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign busy              = busy_q;
    assign frame_done        = done_q;
    assign rd_addr           = addr_q;
    assign valid_out         = !fifo_empty;
    assign startofpacket_out = head.sop;
    assign endofpacket_out   = head.eop;
    assign data_out          = head.data;

endmodule

// File: tb/tb_frame_stream_source.sv
// Bench for frame_stream_source: a small 8x4 instance for protocol corners and
// a full 320x240 instance for the mid-frame reset and full-length frame.
module tb_frame_stream_source;

    localparam int LEN_S  = 32;
    localparam int LEN_L  = 320 * 240;
    localparam int FIFO_D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // small instance signals
    logic        start_s = 1'b0, ready_s = 1'b0;
    logic        busy_s, done_s, rd_en_s, valid_s, sop_s, eop_s;
    logic [16:0] rd_addr_s;
    logic [11:0] rd_data_s, data_s;
    // large instance signals
    logic        start_l = 1'b0, ready_l = 1'b0;
    logic        busy_l, done_l, rd_en_l, valid_l, sop_l, eop_l;
    logic [16:0] rd_addr_l;
    logic [11:0] rd_data_l, data_l;

    frame_stream_source #(.IMG_WIDTH(8), .IMG_HEIGHT(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .frame_done(done_s),
        .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s), .ready_in(ready_s),
        .valid_out(valid_s), .startofpacket_out(sop_s), .endofpacket_out(eop_s),
        .data_out(data_s)
    );

    frame_stream_source dut_l (
        .clk(clk), .rst_n(rst_n), .start(start_l), .busy(busy_l), .frame_done(done_l),
        .rd_en(rd_en_l), .rd_addr(rd_addr_l), .rd_data(rd_data_l), .ready_in(ready_l),
        .valid_out(valid_l), .startofpacket_out(sop_l), .endofpacket_out(eop_l),
        .data_out(data_l)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // frame-buffer models: 1-cycle read latency, garbage when no read was issued
    logic [11:0] mem_s [LEN_S];
    logic [11:0] salt_l = '0;

    function automatic logic [11:0] pix_l(input int idx);
        return 12'(idx * 13) ^ salt_l;
    endfunction

    always @(posedge clk) begin
        rd_data_s <= rd_en_s ? mem_s[rd_addr_s[4:0]] : 12'($urandom);
        rd_data_l <= rd_en_l ? pix_l(int'(rd_addr_l)) : 12'($urandom);
    end

    // expected beats, packed as {sop, eop, data}
    logic [13:0] exp_s[$];
    logic [13:0] exp_l[$];

    task automatic queue_frame_s();
        for (int i = 0; i < LEN_S; i++) begin
            mem_s[i] = 12'($urandom_range(0, 4095));
            exp_s.push_back({i == 0, i == LEN_S - 1, mem_s[i]});
        end
    endtask

    task automatic queue_frame_l();
        for (int i = 0; i < LEN_L; i++) begin
            exp_l.push_back({i == 0, i == LEN_L - 1, pix_l(i)});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_s();
        start_s = 1'b1;
        tick(1);
        start_s = 1'b0;
    endtask

    task automatic pulse_start_l();
        start_l = 1'b1;
        tick(1);
        start_l = 1'b0;
    endtask

    // small-instance scoreboard and protocol monitor
    bit          mon_en = 1'b0;
    bit          act_s = 1'b0, start_pend_s = 1'b0, done_pend_s = 1'b0, done_exp_s = 1'b0;
    bit          first_v_s = 1'b0, stall_seen_s = 1'b0, prev_stall_s = 1'b0;
    logic [14:0] prev_beat_s = '0;
    logic [13:0] exp_beat_s;
    int          cyc_s = 0, issued_s = 0, xfer_s = 0, done_cnt_s = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            act_s = 1'b0; start_pend_s = 1'b0; done_pend_s = 1'b0; prev_stall_s = 1'b0;
            issued_s = 0; xfer_s = 0;
        end else if (mon_en) begin
            done_exp_s  = done_pend_s;
            done_pend_s = 1'b0;
            if (done_exp_s) act_s = 1'b0;
            if (start_pend_s) begin
                act_s = 1'b1; cyc_s = 1; issued_s = 0; xfer_s = 0;
                first_v_s = 1'b0; stall_seen_s = 1'b0;
            end else begin
                cyc_s++;
            end
            start_pend_s = 1'b0;
            check_eq("busy", busy_s, act_s);
            check_eq("frame_done", done_s, done_exp_s);
            if (done_exp_s) begin
                done_cnt_s++;
                check_eq("queue_empty_at_done", exp_s.size(), 0);
                if (!stall_seen_s) check_eq("frame_cycles", cyc_s, LEN_S + 3);
            end
            if (rd_en_s) begin
                check_eq("rd_en_in_frame", act_s, 1);
                check_eq("rd_addr", rd_addr_s, issued_s);
                check_eq("rd_occupancy_ok", (issued_s - xfer_s) < FIFO_D, 1);
                issued_s++;
            end
            if (act_s && !ready_s) stall_seen_s = 1'b1;
            if (prev_stall_s) check_eq("stall_hold", {valid_s, sop_s, eop_s, data_s}, prev_beat_s);
            if (act_s && valid_s && !first_v_s) begin
                first_v_s = 1'b1;
                check_eq("first_valid_cycle", cyc_s, 3);
            end
            if (valid_s && ready_s) begin
                if (exp_s.size() == 0) begin
                    check_eq("extra_beat_valid", valid_s, 0);
                end else begin
                    exp_beat_s = exp_s.pop_front();
                    check_eq("beat", {sop_s, eop_s, data_s}, exp_beat_s);
                    if (exp_beat_s[12]) done_pend_s = 1'b1;
                end
                xfer_s++;
            end
            prev_stall_s = valid_s && !ready_s;
            prev_beat_s  = {valid_s, sop_s, eop_s, data_s};
            start_pend_s = start_s && !act_s;
        end
    end

    // large-instance scoreboard
    int issued_l = 0, xfer_l = 0, done_cnt_l = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_l.delete();
            issued_l = 0;
            xfer_l = 0;
        end else if (mon_en) begin
            if (rd_en_l) begin
                check_eq("l_rd_addr", rd_addr_l, issued_l);
                issued_l++;
            end
            if (valid_l && ready_l) begin
                if (exp_l.size() == 0) check_eq("l_extra_beat_valid", valid_l, 0);
                else check_eq("l_beat", {sop_l, eop_l, data_l}, exp_l.pop_front());
                xfer_l++;
            end
            if (done_l) begin
                done_cnt_l++;
                check_eq("l_queue_empty_at_done", exp_l.size(), 0);
            end
        end
    end

    task automatic run_frame_s(input int mode);
        int d0;
        int last;
        queue_frame_s();
        ready_s = 1'b1;
        pulse_start_s();
        d0 = done_cnt_s;
        last = 0;
        for (int i = 0; i < 2000 && done_cnt_s == d0; i++) begin
            case (mode)
                1: begin
                    if (xfer_s != last && xfer_s % 3 == 0) begin
                        last = xfer_s;
                        ready_s = 1'b0;
                        tick(5);
                        ready_s = 1'b1;
                    end else begin
                        tick(1);
                    end
                end
                2: begin
                    ready_s = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
                default: tick(1);
            endcase
        end
        check_eq("frame_completed", done_cnt_s, d0 + 1);
        ready_s = 1'b1;
    endtask

    task automatic wait_done_s(input int d0);
        for (int i = 0; i < 2000 && done_cnt_s == d0; i++) tick(1);
        check_eq("frame_completed", done_cnt_s, d0 + 1);
    endtask

    initial begin
        int d0;
        // asynchronous reset asserted mid-cycle
        tick(2);
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_async_ctl_s", {valid_s, sop_s, eop_s, rd_en_s, busy_s, done_s}, 0);
        check_eq("rst_async_data_s", data_s, 0);
        check_eq("rst_async_addr_s", rd_addr_s, 0);
        check_eq("rst_async_ctl_l", {valid_l, sop_l, eop_l, rd_en_l, busy_l, done_l}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);
        check_eq("post_rst_ctl_s", {valid_s, sop_s, eop_s, rd_en_s, busy_s, done_s}, 0);
        check_eq("post_rst_data_s", data_s, 0);
        mon_en = 1'b1;

        // full-rate frame, then periodic stalls
        run_frame_s(0);
        run_frame_s(1);

        // downstream not ready when pixel 0 appears
        queue_frame_s();
        ready_s = 1'b0;
        pulse_start_s();
        d0 = done_cnt_s;
        tick(20);
        check_eq("stall_reads", issued_s, FIFO_D);
        check_eq("stall_head", {valid_s, sop_s, data_s}, {1'b1, 1'b1, mem_s[0]});
        ready_s = 1'b1;
        wait_done_s(d0);

        // start while busy is ignored
        queue_frame_s();
        ready_s = 1'b1;
        pulse_start_s();
        d0 = done_cnt_s;
        for (int i = 0; i < 200 && xfer_s < 10; i++) tick(1);
        pulse_start_s();
        wait_done_s(d0);
        tick(5);
        check_eq("idle_after_frame", {busy_s, valid_s}, 0);
        run_frame_s(0);

        // random backpressure
        for (int f = 0; f < 4; f++) run_frame_s(2);

        // full-size frame aborted by reset, then a clean full frame
        salt_l = 12'($urandom);
        queue_frame_l();
        ready_l = 1'b1;
        pulse_start_l();
        for (int i = 0; i < 3000 && xfer_l < 1000; i++) tick(1);
        check_eq("l_reached_1000", xfer_l >= 1000, 1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("l_async_rst", {valid_l, sop_l, eop_l, busy_l, rd_en_l}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);
        salt_l = 12'($urandom);
        queue_frame_l();
        pulse_start_l();
        d0 = done_cnt_l;
        for (int i = 0; i < LEN_L + 100 && done_cnt_l == d0; i++) tick(1);
        check_eq("l_frame_completed", done_cnt_l, d0 + 1);
        check_eq("l_beats", xfer_l, LEN_L);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
